// File: rtl/commit_queue_pkg.sv
// Shared definitions for the commit queue: write-data select codes and the
// packed commit-entry layout for the default configuration.
`ifndef SEL_ALU_DATA
`define SEL_ALU_DATA 1'b1
`endif
`ifndef SEL_MEM_DATA
`define SEL_MEM_DATA 1'b0
`endif

package commit_queue_pkg;

    localparam int unsigned CQ_XLEN   = 32;
    localparam int unsigned CQ_REG_AW = 5;
    localparam int unsigned CQ_CSR_AW = 32;

    typedef struct packed {
        logic                 wena;
        logic [CQ_REG_AW-1:0] waddr;
        logic [CQ_XLEN-1:0]   wdata;
        logic                 csr_wena;
        logic [CQ_CSR_AW-1:0] csr_waddr;
        logic [CQ_XLEN-1:0]   csr_wdata;
    } commit_entry_t;

    localparam int unsigned CQ_ENTRY_W = $bits(commit_entry_t);

    function automatic int unsigned cq_entry_width(input int unsigned xlen,
                                                   input int unsigned reg_aw,
                                                   input int unsigned csr_aw);
        return 2 + reg_aw + csr_aw + 2 * xlen;
    endfunction

endpackage

// File: rtl/commit_hazard_cam.sv
// DEPTH-way destination compare: flags a pending GPR write to one query address.
module commit_hazard_cam #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned REG_AW = 5
) (
    input  logic [DEPTH-1:0]  valid_i,
    input  logic [DEPTH-1:0]  wena_i,
    input  logic [REG_AW-1:0] waddr_i [DEPTH],
    input  logic [REG_AW-1:0] raddr_i,
    output logic              busy_o
);

    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            busy_o = busy_o | (valid_i[i] & wena_i[i] & (waddr_i[i] == raddr_i));
        end
        // x0 never carries a real dependency
        if (raddr_i == '0) begin
            busy_o = 1'b0;
        end
    end

endmodule

// File: rtl/commit_queue.sv
// In-order commit FIFO between the result stage and the GPR/CSR write ports,
// with flush, occupancy and pending-write hazard lookup.
module commit_queue
    import commit_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned XLEN   = CQ_XLEN,
    parameter int unsigned REG_AW = CQ_REG_AW,
    parameter int unsigned CSR_AW = CQ_CSR_AW
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic                     wsel_i,
    input  logic                     wena_i,
    input  logic [REG_AW-1:0]        waddr_i,
    input  logic [XLEN-1:0]          alu_result_i,
    input  logic [XLEN-1:0]          mem_result_i,
    input  logic                     csr_wena_i,
    input  logic [CSR_AW-1:0]        csr_waddr_i,
    input  logic [XLEN-1:0]          csr_wdata_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic                     wena_o,
    output logic [REG_AW-1:0]        waddr_o,
    output logic [XLEN-1:0]          wdata_o,
    output logic                     csr_wena_o,
    output logic [CSR_AW-1:0]        csr_waddr_o,
    output logic [XLEN-1:0]          csr_wdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    input  logic [REG_AW-1:0]        raddr1_i,
    input  logic [REG_AW-1:0]        raddr2_i,
    output logic                     busy1_o,
    output logic                     busy2_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef struct packed {
        logic              wena;
        logic [REG_AW-1:0] waddr;
        logic [XLEN-1:0]   wdata;
        logic              csr_wena;
        logic [CSR_AW-1:0] csr_waddr;
        logic [XLEN-1:0]   csr_wdata;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]   count_q;

    logic              push, pop;
    entry_t            new_entry, head;
    logic [DEPTH-1:0]  ent_valid, ent_wena;
    logic [REG_AW-1:0] ent_waddr [DEPTH];

    always_comb begin
        in_ready_o  = (count_q != CntW'(DEPTH));
        out_valid_o = (count_q != '0);
        push        = in_valid_i & in_ready_o;
        pop         = out_valid_o & out_ready_i;
        count_o     = count_q;

        new_entry.wena      = wena_i & (waddr_i != '0);
        new_entry.waddr     = waddr_i;
        new_entry.wdata     = (wsel_i == `SEL_ALU_DATA) ? alu_result_i : mem_result_i;
        new_entry.csr_wena  = csr_wena_i;
        new_entry.csr_waddr = csr_waddr_i;
        new_entry.csr_wdata = csr_wdata_i;

        head = out_valid_o ? mem_q[rd_ptr_q] : '0;
        waddr_o     = head.waddr;
        wdata_o     = head.wdata;
        csr_waddr_o = head.csr_waddr;
        csr_wdata_o = head.csr_wdata;
        // Strobes stay low while reset is held so no write escapes the reset cycle
        wena_o      = pop & head.wena & reset;
        csr_wena_o  = pop & head.csr_wena & reset;
    end

    // An entry is live if its distance from the read pointer is below the count
    always_comb begin
        logic [PtrW-1:0] offs;
        offs = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            offs         = PtrW'(i) - rd_ptr_q;
            ent_valid[i] = ({1'b0, offs} < count_q);
            ent_wena[i]  = mem_q[i].wena;
            ent_waddr[i] = mem_q[i].waddr;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset && !flush_i && push) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

    commit_hazard_cam #(
        .DEPTH  (DEPTH),
        .REG_AW (REG_AW)
    ) u_cam1 (
        .valid_i (ent_valid),
        .wena_i  (ent_wena),
        .waddr_i (ent_waddr),
        .raddr_i (raddr1_i),
        .busy_o  (busy1_o)
    );

    commit_hazard_cam #(
        .DEPTH  (DEPTH),
        .REG_AW (REG_AW)
    ) u_cam2 (
        .valid_i (ent_valid),
        .wena_i  (ent_wena),
        .waddr_i (ent_waddr),
        .raddr_i (raddr2_i),
        .busy_o  (busy2_o)
    );

endmodule

// File: tb/tb_commit_queue.sv
// Scoreboard bench for commit_queue: stimulus queues expected commits, a
// negedge monitor pops and compares them whenever the head fires.
`ifndef SEL_ALU_DATA
`define SEL_ALU_DATA 1'b1
`endif
`ifndef SEL_MEM_DATA
`define SEL_MEM_DATA 1'b0
`endif

module tb_commit_queue;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush_i, in_valid_i, in_ready_o, wsel_i, wena_i;
    logic [4:0]  waddr_i, raddr1_i, raddr2_i, waddr_o;
    logic [31:0] alu_result_i, mem_result_i, csr_waddr_i, csr_wdata_i;
    logic        out_valid_o, out_ready_i, wena_o, csr_wena_o, csr_wena_i;
    logic [31:0] wdata_o, csr_waddr_o, csr_wdata_o;
    logic [2:0]  count_o;
    logic        busy1_o, busy2_o;

    commit_queue #(.DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .wsel_i       (wsel_i),
        .wena_i       (wena_i),
        .waddr_i      (waddr_i),
        .alu_result_i (alu_result_i),
        .mem_result_i (mem_result_i),
        .csr_wena_i   (csr_wena_i),
        .csr_waddr_i  (csr_waddr_i),
        .csr_wdata_i  (csr_wdata_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .wena_o       (wena_o),
        .waddr_o      (waddr_o),
        .wdata_o      (wdata_o),
        .csr_wena_o   (csr_wena_o),
        .csr_waddr_o  (csr_waddr_o),
        .csr_wdata_o  (csr_wdata_o),
        .count_o      (count_o),
        .raddr1_i     (raddr1_i),
        .raddr2_i     (raddr2_i),
        .busy1_o      (busy1_o),
        .busy2_o      (busy2_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        wena;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        csr_wena;
        logic [31:0] csr_waddr;
        logic [31:0] csr_wdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t pending;
    int   tests = 0;
    int   fails = 0;
    int   mcount = 0;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    // Monitor: compare every fired head against the oldest expected commit
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            check("reset_strobes", {62'd0, wena_o, csr_wena_o}, 64'd0);
        end else if (out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_commit: got waddr %0h wdata %0h expected none",
                         waddr_o, wdata_o);
            end else begin
                e = exp_q.pop_front();
                check("wena_o", {63'd0, wena_o}, {63'd0, e.wena});
                check("waddr_o", {59'd0, waddr_o}, {59'd0, e.waddr});
                check("wdata_o", {32'd0, wdata_o}, {32'd0, e.wdata});
                check("csr_wena_o", {63'd0, csr_wena_o}, {63'd0, e.csr_wena});
                if (e.csr_wena) begin
                    check("csr_waddr_o", {32'd0, csr_waddr_o}, {32'd0, e.csr_waddr});
                    check("csr_wdata_o", {32'd0, csr_wdata_o}, {32'd0, e.csr_wdata});
                end
            end
        end else begin
            check("idle_strobes", {62'd0, wena_o, csr_wena_o}, 64'd0);
        end
    end

    task automatic set_entry(input logic sel, input logic we, input logic [4:0] wa,
                             input logic [31:0] alu, input logic [31:0] mem,
                             input logic cwe, input logic [31:0] ca, input logic [31:0] cd);
        wsel_i = sel; wena_i = we; waddr_i = wa; alu_result_i = alu; mem_result_i = mem;
        csr_wena_i = cwe; csr_waddr_i = ca; csr_wdata_i = cd;
        pending.wena      = we && (wa != 5'd0);
        pending.waddr     = wa;
        pending.wdata     = (sel == `SEL_ALU_DATA) ? alu : mem;
        pending.csr_wena  = cwe;
        pending.csr_waddr = ca;
        pending.csr_wdata = cd;
    endtask

    // One clock: model the expected queue across the edge, then settle inputs after it
    task automatic tick();
        bit push, pop;
        push = in_valid_i && (mcount != DEPTH);
        pop  = (mcount != 0) && out_ready_i;
        @(posedge clock);
        if (!reset || flush_i) begin
            exp_q.delete();
            mcount = 0;
        end else begin
            if (push) exp_q.push_back(pending);
            mcount = mcount + int'(push) - int'(pop);
        end
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        raddr1_i = 5'd0; raddr2_i = 5'd0;
        set_entry(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        tick(); tick();
        reset = 1'b1;
        check("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready_o}, 64'd1);
        check("rst_count", {61'd0, count_o}, 64'd0);
        raddr1_i = 5'd7; raddr2_i = 5'd9;
        #1;
        check("rst_busy", {62'd0, busy1_o, busy2_o}, 64'd0);

        // Single ALU push, committed the cycle after
        set_entry(`SEL_ALU_DATA, 1'b1, 5'd5, 32'h1234, 32'hffff, 1'b0, 32'd0, 32'd0);
        in_valid_i = 1'b1; out_ready_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        check("single_valid", {63'd0, out_valid_o}, 64'd1);
        check("single_waddr", {59'd0, waddr_o}, 64'd5);
        check("single_wdata", {32'd0, wdata_o}, 64'h1234);
        tick();
        check("single_count", {61'd0, count_o}, 64'd0);

        // Fill to DEPTH with the head stalled
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        set_entry(`SEL_ALU_DATA, 1'b1, 5'd7, 32'h11, 32'h0, 1'b1, 32'h300, 32'haa);
        tick();
        set_entry(`SEL_MEM_DATA, 1'b1, 5'd9, 32'h0, 32'h22, 1'b0, 32'h0, 32'h0);
        tick();
        set_entry(`SEL_ALU_DATA, 1'b1, 5'd3, 32'h33, 32'h0, 1'b1, 32'h341, 32'hbeef);
        tick();
        set_entry(`SEL_MEM_DATA, 1'b1, 5'd0, 32'h5555, 32'hdead, 1'b0, 32'h0, 32'h0);
        tick();
        check("full_count", {61'd0, count_o}, 64'd4);
        check("full_in_ready", {63'd0, in_ready_o}, 64'd0);
        raddr1_i = 5'd7; raddr2_i = 5'd8;
        #1;
        check("busy1_x7", {63'd0, busy1_o}, 64'd1);
        check("busy2_x8", {63'd0, busy2_o}, 64'd0);
        raddr1_i = 5'd0; raddr2_i = 5'd9;
        #1;
        check("busy1_x0", {63'd0, busy1_o}, 64'd0);
        check("busy2_x9", {63'd0, busy2_o}, 64'd1);

        // Fifth entry refused while full, even with a pop in the same cycle
        set_entry(`SEL_ALU_DATA, 1'b1, 5'd12, 32'h66, 32'h0, 1'b0, 32'h0, 32'h0);
        tick();
        check("refused_count", {61'd0, count_o}, 64'd4);
        out_ready_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        check("full_pop_count", {61'd0, count_o}, 64'd3);
        raddr1_i = 5'd7;
        #1;
        check("busy1_after_pop", {63'd0, busy1_o}, 64'd0);
        tick(); tick(); tick();
        check("drained_count", {61'd0, count_o}, 64'd0);
        check("drained_valid", {63'd0, out_valid_o}, 64'd0);

        // Flush: head commits, queued and concurrently pushed entries vanish
        out_ready_i = 1'b0; in_valid_i = 1'b1;
        set_entry(`SEL_ALU_DATA, 1'b1, 5'd1, 32'ha1, 32'h0, 1'b0, 32'h0, 32'h0);
        tick();
        set_entry(`SEL_ALU_DATA, 1'b1, 5'd2, 32'ha2, 32'h0, 1'b0, 32'h0, 32'h0);
        tick();
        check("preflush_count", {61'd0, count_o}, 64'd2);
        set_entry(`SEL_ALU_DATA, 1'b1, 5'd4, 32'ha4, 32'h0, 1'b0, 32'h0, 32'h0);
        flush_i = 1'b1; out_ready_i = 1'b1;
        tick();
        flush_i = 1'b0; in_valid_i = 1'b0;
        check("flush_count", {61'd0, count_o}, 64'd0);
        check("flush_valid", {63'd0, out_valid_o}, 64'd0);
        tick(); tick();

        // Steady push+pop at count 2 across pointer wrap
        out_ready_i = 1'b0; in_valid_i = 1'b1;
        set_entry(`SEL_ALU_DATA, 1'b1, 5'd10, 32'h100, 32'h0, 1'b0, 32'h0, 32'h0);
        tick();
        set_entry(`SEL_MEM_DATA, 1'b1, 5'd11, 32'h0, 32'h101, 1'b1, 32'h305, 32'h77);
        tick();
        out_ready_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            set_entry(k[0] ? `SEL_MEM_DATA : `SEL_ALU_DATA, 1'b1, 5'(12 + k),
                      32'h200 + 32'(k), 32'h300 + 32'(k), 1'b0, 32'h0, 32'h0);
            tick();
            check("stream_count", {61'd0, count_o}, 64'd2);
        end

        // Reset mid-stream drops everything without a write strobe
        reset = 1'b0;
        tick();
        reset = 1'b1; in_valid_i = 1'b0;
        check("midrst_valid", {63'd0, out_valid_o}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready_o}, 64'd1);
        check("midrst_count", {61'd0, count_o}, 64'd0);
        tick(); tick();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/commit_queue.md
Name: commit_queue

Overview:
- Parametrised successor to the single-entry commit register: a DEPTH-entry in-order FIFO between the memory/ALU result stage and the GPR/CSR write ports.
- Adds valid/ready handshakes, flush, occupancy count and pending-write (RAW hazard) lookup for two read addresses.
- Selects ALU or memory result at enqueue, so each stored entry holds one final write datum.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
XLEN, 32, GPR/CSR data width
REG_AW, 5, GPR address width
CSR_AW, 32, CSR address width

Ports:
clock  in  1  system clock, all state updates on posedge
reset  in  1  synchronous reset, active-low (reset==0 resets on posedge clock)
flush_i  in  1  discard all queued entries
in_valid_i  in  1  upstream entry valid
in_ready_o  out  1  queue can accept an entry
wsel_i  in  1  `SEL_ALU_DATA selects alu_result_i, otherwise mem_result_i
wena_i  in  1  GPR write enable of entry
waddr_i  in  REG_AW  GPR destination
alu_result_i  in  XLEN  ALU result
mem_result_i  in  XLEN  load result
csr_wena_i  in  1  CSR write enable of entry
csr_waddr_i  in  CSR_AW  CSR address
csr_wdata_i  in  XLEN  CSR data
out_valid_o  out  1  head entry present
out_ready_i  in  1  writeback accepts head
wena_o  out  1  GPR write strobe (fire-qualified)
waddr_o  out  REG_AW  head GPR address
wdata_o  out  XLEN  head GPR data
csr_wena_o  out  1  CSR write strobe (fire-qualified)
csr_waddr_o  out  CSR_AW  head CSR address
csr_wdata_o  out  XLEN  head CSR data
count_o  out  $clog2(DEPTH)+1  occupancy
raddr1_i  in  REG_AW  hazard query address 1
raddr2_i  in  REG_AW  hazard query address 2
busy1_o  out  1  some queued entry writes raddr1_i
busy2_o  out  1  some queued entry writes raddr2_i

Behaviour:
- push = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
- in_ready_o = (count_o != DEPTH); it does not depend on out_ready_i. Full queue with pop in the same cycle still refuses the push.
- out_valid_o = (count_o != 0).
- Enqueue stores:
  - wdata = wsel_i==`SEL_ALU_DATA ? alu_result_i : mem_result_i.
  - wena = wena_i & (waddr_i != 0), so x0 writes are dropped.
  - All other fields are stored verbatim.
- Latency: an entry pushed at edge N is visible at the head after edge N. There is no same-cycle bypass of an empty queue.
- Head outputs waddr_o, wdata_o, csr_waddr_o, csr_wdata_o show the head entry combinationally from storage. They read 0 when empty.
- wena_o = pop & head.wena; csr_wena_o = pop & head.csr_wena. A commit occurs only on fire.
- Pointers: rd_ptr/wr_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH. Count is a separate register:
  - +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push and pop with 0 < count < DEPTH: both happen, count is unchanged.
- Hazard lookup is combinational over valid entries only: busyK_o = OR over valid entries of (wena & waddr == raddrK_i). An address of 0 always gives 0.
- flush_i (synchronous): pointers and count go to 0 at the next edge and any push that cycle is discarded. The pop strobes still fire that cycle, because the head commit is architecturally older than the flush source.
- Reset (reset==0), priority over everything including flush:
  - pointers and count go to 0, so out_valid_o=0, wena_o=0, csr_wena_o=0, busy*=0, in_ready_o=1.
  - Storage contents need no reset.
  - Reset mid-stream loses all entries. No write strobe is asserted during the reset cycle.
- Entry storage is a flat register array; no SRAM inference required.

Decomposition:
- Shared defines package: `SEL_ALU_DATA/`SEL_MEM_DATA and a packed commit-entry layout (wena, waddr, wdata, csr_wena, csr_waddr, csr_wdata) with its total width constant.
- One natural sub-module: commit_hazard_cam, the DEPTH-way address compare producing busy for one query port. It is instantiated twice.

Test Plan:
- Reset then single push with wsel=ALU, waddr=5, alu=0x1234, out_ready=1 -> next cycle out_valid=1, wena_o=1, waddr_o=5, wdata_o=0x1234; following cycle count_o=0.
- Push 4 entries (DEPTH=4) with out_ready=0 -> count_o=4, in_ready_o=0. A 5th in_valid is not accepted. Raise out_ready -> entries 1..4 commit in order, one per cycle.
- Push waddr=0 with wena=1, mem_result=0xdead, wsel=MEM -> at commit wena_o=0 and wdata_o=0xdead. A query raddr1=0 gives busy1_o=0.
- Queue holds writes to x7 and x9; raddr1=7, raddr2=8 -> busy1_o=1, busy2_o=0. After x7 pops, busy1_o=0.
- Count=2 with flush_i=1, in_valid=1, out_ready=1 -> head commits that cycle, then count_o=0 and the pushed entry is absent.
- Continuous push and pop at count=2 across 10 cycles -> count_o stays 2, pointer wrap leaves order intact. Assert reset=0 mid-stream -> next cycle out_valid=0, in_ready=1.
